adc_ram_readout: RTL and testbench
==================================

Name: adc_ram_readout

Overview:
- Downstream consumer of the ADC capture stage: after a capture completes, reads the 128-bit sample words from the capture RAM's read port.
- Serializes each word into four 32-bit beats on a valid/ready stream toward the HPS bridge FIFO.
- One RAM read outstanding at a time; signals completion with a done pulse and a sticky interrupt bit.

Parameters:
- RD_LATENCY, 2, RAM read latency in cycles from oRAMRdEn high to iRAMData valid (legal 1..4)
- ADDR_W, 15, RAM word address width
- MAX_WORDS, 16384, hard cap on words per readout (capture stage never writes beyond address 16383)

Ports:
- clk  in  1  single clock for the whole block
- iReset_n  in  1  asynchronous active-low reset
- iStartReadout  in  1  start request; sampled only in IDLE
- iAbort  in  1  abort any readout in progress
- iStartAddr  in  ADDR_W  first RAM word address
- iReadLength  in  16  number of 128-bit words to read
- iIntClear  in  1  clears oReadoutInterrupt
- oRAMRdEn  out  1  RAM read enable, one cycle per word
- oRAMAddr  out  ADDR_W  RAM read address
- iRAMData  in  128  RAM read data
- oStreamData  out  32  output beat
- oStreamValid  out  1  beat valid
- iStreamReady  in  1  downstream accepts beat
- oBusy  out  1  high in any state other than IDLE
- oReadoutDone  out  1  one-cycle pulse on normal completion
- oReadoutInterrupt  out  1  sticky completion flag
- oWordsRead  out  16  words fully emitted in the current or last readout

Behaviour:
- Reset (async, iReset_n low): state IDLE; all outputs 0, including oRAMAddr and oWordsRead; holding register and counters cleared.
- States: IDLE, ISSUE, WAIT, EMIT, DONE.
- Length: effective length L = min(iReadLength, MAX_WORDS), latched together with iStartAddr at start.
- IDLE: on iStartReadout=1, clear oWordsRead. If L=0 go to DONE, otherwise go to ISSUE. oBusy rises on the next cycle.
- ISSUE: oRAMRdEn=1 for exactly one cycle with oRAMAddr = current address; go to WAIT.
- WAIT: count RD_LATENCY cycles. On the edge RD_LATENCY cycles after the edge that registered oRAMRdEn high, capture iRAMData into the holding register. Go to EMIT with oStreamValid=1 and beat index 0.
- EMIT, beat order: beat0=[31:0], beat1=[63:32], beat2=[95:64], beat3=[127:96].
- EMIT, handshake: a beat transfers on a cycle where oStreamValid && iStreamReady. While valid and not ready, oStreamData and oStreamValid are held stable.
- EMIT, after beat3 transfers: increment oWordsRead and the address. The address wraps modulo 2^ADDR_W, so 32767 is followed by 0.
- EMIT, next state: if oWordsRead+1 == L go to DONE with oStreamValid=0; else go to ISSUE.
- Throughput: minimum 4 + 1 + RD_LATENCY cycles per word.
- DONE: one cycle. oReadoutDone=1 and oReadoutInterrupt set to 1; return to IDLE.
- iAbort=1 in any non-IDLE state: next cycle go to IDLE with oStreamValid=0 and oRAMRdEn=0. oReadoutDone is not pulsed and the interrupt is not set. oWordsRead holds the count of words completed. A pending beat is dropped.
- iAbort in IDLE: no effect. Abort has priority over start.
- iStartReadout while busy: ignored.
- oReadoutInterrupt: cleared by iIntClear=1. If iIntClear and the DONE set occur in the same cycle, set wins.
- iStartReadout and iIntClear together in IDLE: both take effect.

Optional Feature:
- Macro: ADC_RDOUT_TWOS_COMP_EN.
- Defined: each 16-bit lane of the captured word, {4'b0, d[11:0]} (offset binary), is converted at capture time to signed 16-bit two's complement: {{4{~d[11]}}, ~d[11], d[10:0]}.
  - Example: 12'h800 -> 16'h0000, 12'h7FF -> 16'hFFFF, 12'hFFF -> 16'h07FF.
  - No added latency.
- Undefined: words pass through unmodified.

Test Plan:
- Basic readout: start with iStartAddr=0, iReadLength=2, RAM word0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000, iStreamReady=1 -> beats 32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006, then the word1 beats; oRAMRdEn pulses at addresses 0 and 1; oReadoutDone one pulse; oWordsRead=2; oReadoutInterrupt=1.
- Backpressure: iStreamReady low for 5 cycles during beat2 -> oStreamData stays 32'h00050004 with valid held for those 5 cycles; no extra RAM read is issued.
- Boundaries:
  - iReadLength=0 -> no oRAMRdEn, oReadoutDone pulse 2 cycles after start.
  - iReadLength=20000 -> exactly 16384 reads.
  - iStartAddr=32767, iReadLength=2 -> reads at addresses 32767 then 0.
- Abort: iAbort during WAIT of word 3 (iReadLength=10) -> IDLE next cycle, oWordsRead=3, no oReadoutDone, interrupt stays 0; a new start then runs normally.
- Start and interrupt interaction:
  - iStartReadout while busy -> ignored, length unchanged.
  - iIntClear coinciding with DONE -> interrupt remains 1.
  - iReset_n low mid-EMIT -> all outputs 0 immediately.
- With ADC_RDOUT_TWOS_COMP_EN: lanes 12'h800, 12'h7FF, 12'hFFF, 12'h000 -> 16'h0000, 16'hFFFF, 16'h07FF, 16'hF800.

Source files
------------

// File: rtl/adc_ram_readout.sv
// Capture-RAM readout: fetches 128-bit words one at a time and streams each as four 32-bit beats.
// Build option ADC_RDOUT_TWOS_COMP_EN converts each 12-bit offset-binary lane to signed 16-bit on capture.

module adc_rdout_lane #(
    parameter int VEC_W = 16
) (
    input  logic [VEC_W-1:0] d,
    output logic [VEC_W-1:0] q
);
`ifdef ADC_RDOUT_TWOS_COMP_EN
    logic unused_hi;
    assign unused_hi = ^d[VEC_W-1:12];
    // inverting the offset-binary MSB yields the sign; extend it over the upper bits
    assign q = {{(VEC_W-11){~d[11]}}, d[10:0]};
`else
    assign q = d;
`endif
endmodule

module adc_ram_readout #(
    parameter int RD_LATENCY = 2,
    parameter int ADDR_W     = 15,
    parameter int MAX_WORDS  = 16384
) (
    input  logic              clk,
    input  logic              iReset_n,
    input  logic              iStartReadout,
    input  logic              iAbort,
    input  logic [ADDR_W-1:0] iStartAddr,
    input  logic [15:0]       iReadLength,
    input  logic              iIntClear,
    output logic              oRAMRdEn,
    output logic [ADDR_W-1:0] oRAMAddr,
    input  logic [127:0]      iRAMData,
    output logic [31:0]       oStreamData,
    output logic              oStreamValid,
    input  logic              iStreamReady,
    output logic              oBusy,
    output logic              oReadoutDone,
    output logic              oReadoutInterrupt,
    output logic [15:0]       oWordsRead
);
    localparam int          NUM_LANES = 8;
    localparam int          VEC_W     = 16;
    localparam int          STAGES    = RD_LATENCY - 1;
    localparam logic [15:0] MAX_LEN   = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       len;
    } req_t;

    state_t                            state_q, state_d;
    req_t                              start_req, req_q;
    logic [15:0]                       words_q;
    logic [1:0]                        beat_q;
    logic [NUM_LANES-1:0][VEC_W-1:0]   hold_q;
    logic [VEC_W-1:0]                  conv_lane [NUM_LANES];
    logic [STAGES:0]                   vld_pipe;
    logic                              done_q, irq_q;
    logic                              start_acc, wait_done, beat_xfer, last_word, done_set;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        adc_rdout_lane #(.VEC_W(VEC_W)) u_lane (
            .d (iRAMData[g*VEC_W +: VEC_W]),
            .q (conv_lane[g])
        );
    end

    assign start_req.addr = iStartAddr;
    assign start_req.len  = (iReadLength > MAX_LEN) ? MAX_LEN : iReadLength;

    // abort outranks start, so a simultaneous pair leaves the block idle
    assign start_acc = (state_q == S_IDLE) && iStartReadout && !iAbort;
    assign wait_done = (state_q == S_WAIT) && vld_pipe[STAGES];
    assign beat_xfer = (state_q == S_EMIT) && iStreamReady && !iAbort;
    assign last_word = ((words_q + 16'd1) == req_q.len);
    assign done_set  = (state_q == S_DONE) && !iAbort;

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q != S_IDLE && iAbort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start_acc) state_d = (start_req.len == 16'd0) ? S_DONE : S_ISSUE;
                S_ISSUE: state_d = S_WAIT;
                S_WAIT:  if (wait_done) state_d = S_EMIT;
                S_EMIT:  if (beat_xfer && beat_q == 2'd3) state_d = last_word ? S_DONE : S_ISSUE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        oRAMRdEn     = (state_q == S_ISSUE);
        oStreamValid = (state_q == S_EMIT);
        oBusy        = (state_q != S_IDLE);
    end

    // vld_pipe[k] is high in the (k+1)-th WAIT cycle; the last stage marks RAM data valid
    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            vld_pipe <= '0;
        end else if (iAbort) begin
            vld_pipe <= '0;
        end else begin
            for (int i = STAGES; i > 0; i--) vld_pipe[i] <= vld_pipe[i-1];
            vld_pipe[0] <= (state_q == S_ISSUE);
        end
    end

    always_ff @(posedge clk or negedge iReset_n) begin
        if (!iReset_n) begin
            req_q   <= '0;
            words_q <= '0;
            beat_q  <= '0;
            hold_q  <= '0;
            done_q  <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            done_q <= done_set;
            if (done_set)       irq_q <= 1'b1;
            else if (iIntClear) irq_q <= 1'b0;
            if (start_acc) begin
                req_q   <= start_req;
                words_q <= '0;
            end
            if (wait_done && !iAbort) begin
                for (int i = 0; i < NUM_LANES; i++) hold_q[i] <= conv_lane[i];
                beat_q <= '0;
            end
            if (beat_xfer) begin
                beat_q <= beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    words_q    <= words_q + 16'd1;
                    req_q.addr <= req_q.addr + ADDR_W'(1);
                end
            end
        end
    end

    assign oStreamData       = {hold_q[{beat_q, 1'b1}], hold_q[{beat_q, 1'b0}]};
    assign oRAMAddr          = req_q.addr;
    assign oWordsRead        = words_q;
    assign oReadoutDone      = done_q;
    assign oReadoutInterrupt = irq_q;

endmodule

// File: tb/tb_adc_ram_readout.sv
// Randomized scoreboard bench for adc_ram_readout with a synchronous RAM model.
// Expected beats and read addresses are queued at stimulus time and popped by an output monitor.

module tb_adc_ram_readout;
    localparam int RD_LAT = 2;
    localparam int AW     = 15;
    localparam int MAXW   = 512;
    localparam int DEPTH  = 1 << AW;

    logic          clk = 1'b0;
    logic          iReset_n = 1'b1;
    logic          iStartReadout = 1'b0;
    logic          iAbort = 1'b0;
    logic [AW-1:0] iStartAddr = '0;
    logic [15:0]   iReadLength = '0;
    logic          iIntClear = 1'b0;
    logic          oRAMRdEn;
    logic [AW-1:0] oRAMAddr;
    logic [127:0]  iRAMData;
    logic [31:0]   oStreamData;
    logic          oStreamValid;
    logic          iStreamReady = 1'b0;
    logic          oBusy;
    logic          oReadoutDone;
    logic          oReadoutInterrupt;
    logic [15:0]   oWordsRead;

    adc_ram_readout #(.RD_LATENCY(RD_LAT), .ADDR_W(AW), .MAX_WORDS(MAXW)) dut (
        .clk               (clk),
        .iReset_n          (iReset_n),
        .iStartReadout     (iStartReadout),
        .iAbort            (iAbort),
        .iStartAddr        (iStartAddr),
        .iReadLength       (iReadLength),
        .iIntClear         (iIntClear),
        .oRAMRdEn          (oRAMRdEn),
        .oRAMAddr          (oRAMAddr),
        .iRAMData          (iRAMData),
        .oStreamData       (oStreamData),
        .oStreamValid      (oStreamValid),
        .iStreamReady      (iStreamReady),
        .oBusy             (oBusy),
        .oReadoutDone      (oReadoutDone),
        .oReadoutInterrupt (oReadoutInterrupt),
        .oWordsRead        (oWordsRead)
    );

    always #5 clk = ~clk;

    logic [127:0]  mem [DEPTH];
    logic [127:0]  rpipe [RD_LAT];
    logic [31:0]   exp_beats [$];
    logic [AW-1:0] exp_addrs [$];
    int            n_checks = 0, n_fail = 0, rd_cnt = 0, done_cnt = 0;
    bit            rand_rdy = 1'b0;

    // synchronous RAM: samples address on the edge that sees read enable, data after RD_LAT edges
    always @(posedge clk) begin
        rpipe[0] <= oRAMRdEn ? mem[oRAMAddr] : {4{32'hDEADBEEF}};
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign iRAMData = rpipe[RD_LAT-1];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_val(input logic [15:0] x);
`ifdef ADC_RDOUT_TWOS_COMP_EN
        return 16'(int'(x[11:0]) - 2048);
`else
        return x;
`endif
    endfunction

    task automatic expect_run(input int addr, input int n);
        for (int w = 0; w < n; w++) begin
            int a;
            logic [127:0] d;
            a = (addr + w) % DEPTH;
            d = mem[a];
            exp_addrs.push_back(AW'(a));
            for (int b = 0; b < 4; b++)
                exp_beats.push_back({lane_val(d[32*b+16 +: 16]), lane_val(d[32*b +: 16])});
        end
    endtask

    always @(negedge clk) begin
        if (oStreamValid && iStreamReady) begin
            if (exp_beats.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL beat: got unexpected beat %0h, required none", oStreamData);
            end else begin
                check("beat", {96'b0, oStreamData}, {96'b0, exp_beats.pop_front()});
            end
        end
        if (oRAMRdEn) begin
            rd_cnt++;
            if (exp_addrs.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_addr: got unexpected read at %0h, required none", oRAMAddr);
            end else begin
                check("rd_addr", {113'b0, oRAMAddr}, {113'b0, exp_addrs.pop_front()});
            end
        end
        if (oReadoutDone) done_cnt++;
    end

    task automatic step();
        @(posedge clk); #1;
        if (rand_rdy) iStreamReady = ($urandom_range(0, 3) != 0);
    endtask

    task automatic start_rd(input int addr, input int len);
        iStartAddr = AW'(addr);
        iReadLength = 16'(len);
        iStartReadout = 1'b1;
        step();
        iStartReadout = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (oBusy && t < 20000) begin step(); t++; end
        if (oBusy) begin
            n_checks++; n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, t);
        end
        step(); step();
    endtask

    task automatic wait_valid(input string name);
        int t;
        t = 0;
        while (!oStreamValid && t < 100) begin step(); t++; end
        if (!oStreamValid) begin
            n_checks++; n_fail++;
            $display("FAIL %s: no valid beat within %0d cycles, required one", name, t);
        end
    endtask

    task automatic clear_irq();
        iIntClear = 1'b1; step(); iIntClear = 1'b0;
    endtask

    initial begin
        int a, n, r0, d0, t;
        logic [31:0] exp_b2;

        for (int i = 0; i < DEPTH; i++)
            mem[i] = {$urandom, $urandom, $urandom, $urandom} & {8{16'h0FFF}};
        mem[0]   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
        mem[100] = 128'h0000_0000_0000_0000_0000_0FFF_07FF_0800;

        #2 iReset_n = 1'b0;
        repeat (3) step();
        check("reset_outputs", {oRAMRdEn, oRAMAddr, oStreamData, oStreamValid, oBusy,
                                oReadoutDone, oReadoutInterrupt, oWordsRead}, '0);
        iReset_n = 1'b1;
        step();

        // basic two-word readout
        iStreamReady = 1'b1;
        expect_run(0, 2);
        r0 = rd_cnt; d0 = done_cnt;
        start_rd(0, 2);
        check("basic_busy", oBusy, 1);
        wait_idle("basic");
        check("basic_drained", exp_beats.size(), 0);
        check("basic_reads", rd_cnt - r0, 2);
        check("basic_done", done_cnt - d0, 1);
        check("basic_words", oWordsRead, 2);
        check("basic_irq", oReadoutInterrupt, 1);
        clear_irq();
        check("irq_clear", oReadoutInterrupt, 0);

        // backpressure on beat2
        exp_b2 = {lane_val(16'h0005), lane_val(16'h0004)};
        expect_run(0, 1);
        iStreamReady = 1'b0;
        r0 = rd_cnt;
        start_rd(0, 1);
        wait_valid("bp_valid_wait");
        iStreamReady = 1'b1;
        step(); step();
        iStreamReady = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("bp_data", oStreamData, exp_b2);
            check("bp_valid", oStreamValid, 1);
            step();
        end
        iStreamReady = 1'b1;
        wait_idle("bp");
        check("bp_reads", rd_cnt - r0, 1);
        check("bp_drained", exp_beats.size(), 0);

        // zero length, with interrupt clear colliding with the set
        clear_irq();
        r0 = rd_cnt; d0 = done_cnt;
        start_rd(5, 0);
        check("len0_busy", oBusy, 1);
        check("len0_early_done", oReadoutDone, 0);
        iIntClear = 1'b1;
        step();
        iIntClear = 1'b0;
        check("len0_done", oReadoutDone, 1);
        check("len0_irq_set_wins", oReadoutInterrupt, 1);
        step();
        check("len0_reads", rd_cnt - r0, 0);
        check("len0_done_cnt", done_cnt - d0, 1);

        // length above the cap
        a = $urandom_range(0, DEPTH - 1);
        expect_run(a, MAXW);
        r0 = rd_cnt;
        start_rd(a, 20000);
        wait_idle("cap");
        check("cap_reads", rd_cnt - r0, MAXW);
        check("cap_words", oWordsRead, MAXW);
        check("cap_drained", exp_beats.size(), 0);

        // address wrap
        expect_run(DEPTH - 1, 2);
        r0 = rd_cnt;
        start_rd(DEPTH - 1, 2);
        wait_idle("wrap");
        check("wrap_reads", rd_cnt - r0, 2);
        check("wrap_drained", exp_addrs.size() + exp_beats.size(), 0);

        // abort in the WAIT of the fourth word
        clear_irq();
        a = $urandom_range(0, DEPTH - 1);
        expect_run(a, 3);
        exp_addrs.push_back(AW'((a + 3) % DEPTH));
        d0 = done_cnt;
        start_rd(a, 10);
        t = 0;
        while (!(oRAMRdEn && oWordsRead == 16'd3) && t < 500) begin step(); t++; end
        check("abort_reached_word3", {oRAMRdEn, oWordsRead}, {1'b1, 16'd3});
        step();
        iAbort = 1'b1;
        step();
        iAbort = 1'b0;
        check("abort_idle", {oBusy, oStreamValid, oRAMRdEn}, 3'b000);
        check("abort_words", oWordsRead, 3);
        repeat (3) step();
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_irq", oReadoutInterrupt, 0);
        check("abort_drained", exp_addrs.size() + exp_beats.size(), 0);
        a = $urandom_range(0, DEPTH - 1);
        expect_run(a, 2);
        d0 = done_cnt;
        start_rd(a, 2);
        wait_idle("post_abort");
        check("post_abort_words", oWordsRead, 2);
        check("post_abort_done", done_cnt - d0, 1);

        // start while busy is ignored
        a = $urandom_range(0, DEPTH - 1);
        expect_run(a, 3);
        start_rd(a, 3);
        repeat (4) step();
        start_rd((a + 50) % DEPTH, 7);
        wait_idle("busy_start");
        check("busy_start_words", oWordsRead, 3);
        check("busy_start_drained", exp_beats.size(), 0);

        // randomized runs with random backpressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            a = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 6);
            expect_run(a, n);
            start_rd(a, n);
            wait_idle("rand");
            check("rand_words", oWordsRead, n);
            check("rand_drained", exp_addrs.size() + exp_beats.size(), 0);
        end
        rand_rdy = 1'b0;
        iStreamReady = 1'b1;

        // lane conversion corner values
        exp_addrs.push_back(AW'(100));
`ifdef ADC_RDOUT_TWOS_COMP_EN
        exp_beats.push_back(32'hFFFF_0000);
        exp_beats.push_back(32'hF800_07FF);
        exp_beats.push_back(32'hF800_F800);
        exp_beats.push_back(32'hF800_F800);
`else
        exp_beats.push_back(32'h07FF_0800);
        exp_beats.push_back(32'h0000_0FFF);
        exp_beats.push_back(32'h0000_0000);
        exp_beats.push_back(32'h0000_0000);
`endif
        start_rd(100, 1);
        wait_idle("lanes");
        check("lanes_drained", exp_beats.size(), 0);

        // reset during EMIT
        expect_run(0, 2);
        start_rd(0, 2);
        wait_valid("rst_valid_wait");
        iReset_n = 1'b0;
        #1;
        check("rst_mid_outputs", {oRAMRdEn, oRAMAddr, oStreamData, oStreamValid, oBusy,
                                  oReadoutDone, oReadoutInterrupt, oWordsRead}, '0);
        exp_beats.delete();
        exp_addrs.delete();
        step();
        iReset_n = 1'b1;
        step();
        check("rst_mid_idle", oBusy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
